// File: rtl/column_window_gen_fp16_if.sv
// Pixel stream in, column window out; the slave side is the window generator.
// Coordinates and the qualifier travel alongside the pixel on both sides.
interface column_window_gen_fp16_if #(
  parameter int FP_WIDTH_REG  = 16,
  parameter int WINDOW_HEIGHT = 4,
  parameter int WINDOW_WIDTH  = 1
);
  logic [FP_WIDTH_REG-1:0]                                      data_i;
  logic [15:0]                                                  col_i;
  logic [15:0]                                                  row_i;
  logic                                                         valid_i;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
  logic [15:0]                                                  col_o;
  logic [15:0]                                                  row_o;
  logic                                                         valid_o;

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  window_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/column_window_gen_fp16.sv
// Vertical WINDOW_HEIGHT x 1 window over a raster fp16 stream; 2-cycle latency, no backpressure.
// Rows above the frame top (or not yet received) are masked to +0.0.
module column_window_gen_fp16 #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int WINDOW_HEIGHT = 4,
  parameter int WINDOW_WIDTH  = 1,
  parameter int IMAGE_WIDTH   = 640
) (
  input logic                    clk_i,
  input logic                    rst_i,
  column_window_gen_fp16_if.slave pix
);
  localparam int NBUF = WINDOW_HEIGHT - 1;
  localparam int AW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RSW  = $clog2(WINDOW_HEIGHT);
  localparam logic [15:0]    LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [RSW-1:0] RS_MAX   = RSW'(WINDOW_HEIGHT - 1);

  typedef logic [FP_WIDTH_REG-1:0] word_t;
  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

  if (WINDOW_WIDTH != 1) begin : g_bad_width
    $error("column_window_gen_fp16: WINDOW_WIDTH must be 1");
  end
  if (WINDOW_HEIGHT < 2) begin : g_bad_height
    $error("column_window_gen_fp16: WINDOW_HEIGHT must be >= 2");
  end

  word_t          mem [NBUF][IMAGE_WIDTH];
  word_t          rd_q [NBUF];
  word_t          data_s1;
  logic [15:0]    col_s1, row_s1;
  logic [AW-1:0]  addr_s1;
  logic           vld_s1;
  logic [RSW-1:0] rs_s1;
  logic [RSW-1:0] rows_seen, rs_eff, rs_next;
  logic [AW-1:0]  addr;
  logic           accept, fwd;
  win_t           win_nxt;

  always_comb begin
    accept  = pix.valid_i && (pix.col_i <= LAST_COL);
    addr    = pix.col_i[AW-1:0];
    rs_eff  = (pix.col_i == '0 && pix.row_i == '0) ? '0 : rows_seen;
    rs_next = rs_eff;
    if (pix.col_i == LAST_COL && rs_eff != RS_MAX) rs_next = rs_eff + RSW'(1);
    // Deeper buffers are written one cycle late; bypass that pending write.
    fwd     = vld_s1 && (addr_s1 == addr);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[0][addr] <= pix.data_i;
      for (int k = 0; k < NBUF; k++) rd_q[k] <= mem[k][addr];
      for (int k = 1; k < NBUF; k++) if (fwd) rd_q[k] <= rd_q[k-1];
    end
    if (vld_s1) begin
      for (int k = 1; k < NBUF; k++) mem[k][addr_s1] <= rd_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_s1    <= 1'b0;
      rows_seen <= '0;
    end else begin
      vld_s1 <= accept;
      if (accept) begin
        data_s1   <= pix.data_i;
        col_s1    <= pix.col_i;
        row_s1    <= pix.row_i;
        addr_s1   <= addr;
        rs_s1     <= rs_eff;
        rows_seen <= rs_next;
      end
    end
  end

  always_comb begin
    win_nxt = '0;
    win_nxt[WINDOW_HEIGHT-1][0] = data_s1;
    for (int k = 0; k < NBUF; k++) begin
      win_nxt[WINDOW_HEIGHT-2-k][0] = (rs_s1 > RSW'(k)) ? rd_q[k] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix.valid_o  <= 1'b0;
      pix.col_o    <= '0;
      pix.row_o    <= '0;
      pix.window_o <= '0;
    end else begin
      pix.valid_o <= vld_s1;
      if (vld_s1) begin
        pix.window_o <= win_nxt;
        pix.col_o    <= col_s1;
        pix.row_o    <= row_s1;
      end
    end
  end
endmodule

// File: tb/tb_column_window_gen_fp16.sv
// Bench for column_window_gen_fp16 with IMAGE_WIDTH=4: scoreboard against a frame
// model plus a table of hand-derived windows at selected coordinates.
module tb_column_window_gen_fp16;
  localparam int H  = 4;
  localparam int IW = 4;
  localparam int NR = 6;

  typedef struct {
    logic [63:0] win;
    logic [15:0] col;
    logic [15:0] row;
    int          cyc;
  } exp_t;

  typedef struct {
    int          fid;
    int          r;
    int          c;
    logic [63:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  column_window_gen_fp16_if #(.FP_WIDTH_REG(16), .WINDOW_HEIGHT(H), .WINDOW_WIDTH(1)) bus ();

  column_window_gen_fp16 #(.WINDOW_HEIGHT(H), .WINDOW_WIDTH(1), .IMAGE_WIDTH(IW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pix   (bus)
  );

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic [15:0] img [NR][IW];
  logic [63:0] cap [NR][IW];
  int          cyc = 0;
  int          nvec = 0, nerr = 0, nout = 0, nacc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Window flattened as {[0],[1],[2],[3]}, oldest row in the top bits.
  function automatic logic [63:0] flat();
    return {bus.window_o[0][0], bus.window_o[1][0], bus.window_o[2][0], bus.window_o[3][0]};
  endfunction

  function automatic logic [63:0] exp_win(input int r, input int c);
    logic [63:0] e;
    e = '0;
    for (int j = 0; j < H; j++)
      if (r - 3 + j >= 0 && r - 3 + j < NR) e[63-16*j -: 16] = img[r-3+j][c];
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_o) begin
      nout++;
      if (sbq.size() == 0) begin
        check("unexpected_valid", 64'(bus.valid_o), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("sb_window", flat(), e.win);
        check("sb_col", 64'(bus.col_o), 64'(e.col));
        check("sb_row", 64'(bus.row_o), 64'(e.row));
        check("sb_latency", 64'(cyc), 64'(e.cyc));
        if (bus.row_o < 16'(NR) && bus.col_o < 16'(IW)) cap[bus.row_o][bus.col_o] = flat();
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input int c, input int r);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.col_i   = 16'(c);
    bus.row_i   = 16'(r);
    if (v && c < IW) begin
      sbq.push_back('{exp_win(r, c), 16'(c), 16'(r), cyc + 2});
      nacc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    foreach (cap[i, j]) cap[i][j] = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  task automatic run_frame(input int nrows, input int gap_pct, input bit bad);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < IW; c++) begin
        while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 16'h0, 0, 0);
        if (bad && r == 2 && c == 2) begin
          drive(1'b1, 16'h7BFF, 7, 2);
          drive(1'b0, 16'h0, 0, 0);
          check("bad_col_slot_valid", 64'(bus.valid_o), 64'd0);
        end
        drive(1'b1, img[r][c], c, r);
      end
    end
    repeat (4) drive(1'b0, 16'h0, 0, 0);
  endtask

  task automatic check_table(input int fid);
    foreach (tbl[i])
      if (tbl[i].fid == fid)
        check($sformatf("win_f%0d_r%0d_c%0d", fid, tbl[i].r, tbl[i].c), cap[tbl[i].r][tbl[i].c], tbl[i].w);
  endtask

  task automatic load_rows();
    logic [15:0] rv [NR];
    rv = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
    foreach (img[i, j]) img[i][j] = rv[i];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t keep[$];
    tbl.push_back('{0, 3, 2, 64'h0000_3C00_4000_4200});
    tbl.push_back('{0, 1, 0, 64'h0000_0000_0000_3C00});
    tbl.push_back('{0, 0, 3, 64'h0000_0000_0000_0000});
    tbl.push_back('{0, 2, 1, 64'h0000_0000_3C00_4000});
    tbl.push_back('{0, 4, 0, 64'h3C00_4000_4200_4400});
    tbl.push_back('{0, 5, 3, 64'h4000_4200_4400_4500});
    tbl.push_back('{1, 1, 0, 64'h0000_0000_4800_3C00});
    tbl.push_back('{1, 3, 1, 64'h4800_3C00_4000_4200});
    tbl.push_back('{1, 4, 2, 64'h3C00_4000_4200_4400});
    tbl.push_back('{3, 0, 0, 64'h0000_0000_0000_3C00});
    tbl.push_back('{3, 0, 3, 64'h0000_0000_0000_3C00});
    tbl.push_back('{3, 1, 2, 64'h0000_0000_3C00_3C00});

    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.col_i   = '0;
    bus.row_i   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_window", flat(), 64'd0);
    check("rst_col", 64'(bus.col_o), 64'd0);
    check("rst_row", 64'(bus.row_o), 64'd0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 0, 0);
    drive(1'b0, 16'h0, 0, 0);
    check("idle_valid", 64'(bus.valid_o), 64'd0);
    check("idle_window", flat(), 64'd0);

    // Gapless frame, row value as pixel
    load_rows();
    clear_cap();
    run_frame(NR, 0, 1'b0);
    check_table(0);

    // Non-zero top row shows row 0 is real data, rows above are masked
    foreach (img[0][j]) img[0][j] = 16'h4800;
    clear_cap();
    run_frame(NR, 0, 1'b0);
    check_table(1);

    // Random gaps plus an out-of-range column mid-row
    load_rows();
    clear_cap();
    run_frame(NR, 50, 1'b1);
    check_table(0);

    // Reset in the middle of row 4, then a fresh frame of 0x3C00
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < IW; c++) drive(1'b1, img[r][c], c, r);
    drive(1'b1, img[4][0], 0, 4);
    drive(1'b1, img[4][1], 1, 4);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc <= cyc) keep.push_back(sbq[i]);
      else nacc--;
    end
    sbq = keep;
    @(posedge clk);
    #1;
    check("rst_mid_valid0", 64'(bus.valid_o), 64'd0);
    check("rst_mid_window0", flat(), 64'd0);
    @(posedge clk);
    #1;
    check("rst_mid_valid1", 64'(bus.valid_o), 64'd0);
    rst = 1'b0;
    foreach (img[i, j]) img[i][j] = 16'h3C00;
    clear_cap();
    run_frame(2, 0, 1'b0);
    check_table(3);

    check("out_count", 64'(nout), 64'(nacc));
    check("queue_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
